// File: rtl/fetch_queue_stage.sv
// fetch_queue_stage: PC generation, inst SRAM requests and a DEPTH-entry {pc,inst} queue.
// Optional macro FQ_BYPASS_EN: forward a response straight to ID when the queue is empty.
module fetch_queue_stage #(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32,
  parameter int DEPTH  = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h1c000000
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         stall,
  input  logic                         br_taken,
  input  logic [ADDR_W-1:0]            br_target,
  output logic                         inst_sram_en,
  output logic [ADDR_W-1:0]            inst_sram_addr,
  input  logic [INST_W-1:0]            inst_sram_rdata,
  input  logic                         ds_allow_in,
  output logic                         fs_to_ds_valid,
  output logic [ADDR_W-1:0]            fs_pc,
  output logic [INST_W-1:0]            fs_inst,
  output logic [$clog2(DEPTH+1)-1:0]   fq_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int EW = ADDR_W + INST_W;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] req_pc;
  logic              inflight;
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;
  logic [CW-1:0]     count;
  logic [EW-1:0]     mem [DEPTH];

  logic [CW:0]       credit;
  logic              req;
  logic              push;
  logic              pop;
  logic              byp;
  logic              wr_en;
  logic              rd_en;
  logic [EW-1:0]     head;

  // Credit = stored entries plus the one response still on its way.
  always_comb begin
    credit = {1'b0, count} + {{CW{1'b0}}, inflight};
  end

  assign req  = !reset && !stall && !br_taken && (credit < DEPTH_C);
  assign push = inflight && !br_taken && !reset;
  assign head = mem[rd_ptr];

  assign inst_sram_en   = req;
  assign inst_sram_addr = pc;
  assign fq_count       = count;

`ifdef FQ_BYPASS_EN
  assign byp            = push && (count == '0);
  assign fs_to_ds_valid = (count != '0) || byp;
  assign fs_pc          = byp ? req_pc : head[EW-1:INST_W];
  assign fs_inst        = byp ? inst_sram_rdata : head[INST_W-1:0];
`else
  assign byp            = 1'b0;
  assign fs_to_ds_valid = (count != '0);
  assign fs_pc          = head[EW-1:INST_W];
  assign fs_inst        = head[INST_W-1:0];
`endif

  // A bypassed entry that ID takes never touches storage.
  assign pop   = fs_to_ds_valid && ds_allow_in && !br_taken;
  assign wr_en = push && !(byp && ds_allow_in);
  assign rd_en = pop && !byp;

  // PC and in-flight tracking; redirect cancels the pending response.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc       <= RESET_PC;
      req_pc   <= RESET_PC;
      inflight <= 1'b0;
    end else if (br_taken) begin
      pc       <= br_target;
      inflight <= 1'b0;
    end else begin
      inflight <= req;
      if (req) begin
        pc     <= pc + ADDR_W'(4);
        req_pc <= pc;
      end
    end
  end

  // Queue pointers and occupancy; pop and push may share a cycle.
  always_ff @(posedge clk) begin
    if (reset || br_taken) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PW'(1);
      if (rd_en) rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(wr_en) - CW'(rd_en);
    end
  end

  // Entry storage, written with the returning {pc, inst} pair.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= {req_pc, inst_sram_rdata};
  end

endmodule

// File: tb/tb_fetch_queue_stage.sv
// tb_fetch_queue_stage: fetch queue bench with an SRAM model and a queue-based
// reference of the fetch/flush/pop rules.
module tb_fetch_queue_stage;

  localparam logic [31:0] RST_PC = 32'h1c000000;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        br_taken;
  logic [31:0] br_target;
  logic        inst_sram_en;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_rdata;
  logic        ds_allow_in;
  logic        fs_to_ds_valid;
  logic [31:0] fs_pc;
  logic [31:0] fs_inst;
  logic [2:0]  fq_count;

  fetch_queue_stage dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .br_taken       (br_taken),
    .br_target      (br_target),
    .inst_sram_en   (inst_sram_en),
    .inst_sram_addr (inst_sram_addr),
    .inst_sram_rdata(inst_sram_rdata),
    .ds_allow_in    (ds_allow_in),
    .fs_to_ds_valid (fs_to_ds_valid),
    .fs_pc          (fs_pc),
    .fs_inst        (fs_inst),
    .fq_count       (fq_count)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] m_q[$];
  logic [31:0] m_pc;
  logic [31:0] m_req_pc;
  logic        m_inf;
  bit          m_init = 0;

  bit           chk;
  logic [100:0] obs_vec;
  logic [100:0] exp_vec;
  logic         obs_en;
  logic         obs_valid;
  logic [31:0]  obs_addr;
  logic [31:0]  obs_pc;
  logic [2:0]   obs_cnt;
  logic [31:0]  last_req;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5a5ac3c3;
  endfunction

  task automatic tick();
    logic        e_en;
    logic        e_valid;
    logic [31:0] e_pc;
    logic        sreq;
    logic [31:0] saddr;
    @(negedge clk);
    obs_en    = inst_sram_en;
    obs_addr  = inst_sram_addr;
    obs_valid = fs_to_ds_valid;
    obs_pc    = fs_pc;
    obs_cnt   = fq_count;
    if (inst_sram_en) last_req = inst_sram_addr;
    obs_vec = {inst_sram_en, inst_sram_en ? inst_sram_addr : 32'h0,
               fs_to_ds_valid, fs_to_ds_valid ? fs_pc : 32'h0,
               fs_to_ds_valid ? fs_inst : 32'h0, fq_count};
    chk = m_init;
    e_en = !reset && !stall && !br_taken &&
           (m_q.size() + int'(m_inf) < 4);
    e_valid = (m_q.size() != 0);
    e_pc = e_valid ? m_q[0] : 32'h0;
    exp_vec = {e_en, e_en ? m_pc : 32'h0, e_valid, e_pc,
               e_valid ? inst_of(e_pc) : 32'h0, 3'(m_q.size())};
    if (reset) begin
      m_q.delete();
      m_pc = RST_PC;
      m_inf = 1'b0;
      m_init = 1;
    end else if (br_taken) begin
      m_q.delete();
      m_pc = br_target;
      m_inf = 1'b0;
    end else begin
      if (e_valid && ds_allow_in) void'(m_q.pop_front());
      if (m_inf) m_q.push_back(m_req_pc);
      if (e_en) begin
        m_req_pc = m_pc;
        m_pc = m_pc + 32'd4;
      end
      m_inf = e_en;
    end
    sreq  = inst_sram_en;
    saddr = inst_sram_addr;
    @(posedge clk);
    #1;
    inst_sram_rdata = sreq ? inst_of(saddr) : $urandom;
  endtask

  task automatic do_reset();
    reset = 1'b1; stall = 1'b0; br_taken = 1'b0; ds_allow_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (chk) begin
        vectors++;
        if (obs_vec !== exp_vec) begin
          $display("FAIL reset_hold got %h exp %h", obs_vec, exp_vec);
          miscompares++;
        end
      end
    end
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if (obs_en !== 1'b0 || obs_valid !== 1'b0 || obs_cnt !== 3'd0) begin
      $display("FAIL reset_state got en=%b v=%b cnt=%0d exp 0 0 0",
               obs_en, obs_valid, obs_cnt);
      miscompares++;
    end
    ds_allow_in = 1'b1;
    tick();
    vectors++;
    if (obs_en !== 1'b1 || obs_addr !== RST_PC) begin
      $display("FAIL first_fetch got en=%b addr=%h exp 1 %h",
               obs_en, obs_addr, RST_PC);
      miscompares++;
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      vectors++;
      if (obs_vec !== exp_vec) begin
        $display("FAIL stream got %h exp %h", obs_vec, exp_vec);
        miscompares++;
      end
    end
  endtask

  task automatic test_backpressure();
    int nreq;
    do_reset();
    nreq = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (obs_en) nreq++;
      vectors++;
      if (obs_vec !== exp_vec) begin
        $display("FAIL bp_hold got %h exp %h", obs_vec, exp_vec);
        miscompares++;
      end
    end
    vectors++;
    if (nreq != 4 || obs_cnt !== 3'd4) begin
      $display("FAIL bp_credit got req=%0d cnt=%0d exp 4 4", nreq, obs_cnt);
      miscompares++;
    end
    ds_allow_in = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      vectors++;
      if (obs_vec !== exp_vec) begin
        $display("FAIL bp_drain got %h exp %h", obs_vec, exp_vec);
        miscompares++;
      end
    end
  endtask

  task automatic test_redirect();
    do_reset();
    for (int i = 0; i < 12 && !(m_q.size() == 3 && m_inf); i++) tick();
    vectors++;
    if (!(m_q.size() == 3 && m_inf)) begin
      $display("FAIL br_setup timeout got cnt=%0d exp 3", obs_cnt);
      miscompares++;
    end
    br_taken = 1'b1;
    br_target = 32'h1c000100;
    tick();
    br_taken = 1'b0;
    ds_allow_in = 1'b1;
    tick();
    vectors++;
    if (obs_cnt !== 3'd0 || obs_valid !== 1'b0 ||
        obs_en !== 1'b1 || obs_addr !== 32'h1c000100) begin
      $display("FAIL br_flush got cnt=%0d v=%b en=%b addr=%h exp 0 0 1 1c000100",
               obs_cnt, obs_valid, obs_en, obs_addr);
      miscompares++;
    end
    for (int i = 0; i < 5 && !obs_valid; i++) tick();
    vectors++;
    if (obs_valid !== 1'b1 || obs_pc !== 32'h1c000100) begin
      $display("FAIL br_first_pc got v=%b pc=%h exp 1 1c000100",
               obs_valid, obs_pc);
      miscompares++;
    end
    br_taken = 1'b1;
    br_target = 32'hfffffff8;
    tick();
    br_taken = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      vectors++;
      if (obs_vec !== exp_vec) begin
        $display("FAIL pc_wrap got %h exp %h", obs_vec, exp_vec);
        miscompares++;
      end
    end
  endtask

  task automatic test_stall();
    logic [31:0] resume;
    do_reset();
    ds_allow_in = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    resume = last_req + 32'd4;
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      vectors++;
      if (obs_vec !== exp_vec) begin
        $display("FAIL stall got %h exp %h", obs_vec, exp_vec);
        miscompares++;
      end
    end
    vectors++;
    if (obs_cnt !== 3'd0) begin
      $display("FAIL stall_drain got cnt=%0d exp 0", obs_cnt);
      miscompares++;
    end
    stall = 1'b0;
    tick();
    vectors++;
    if (obs_en !== 1'b1 || obs_addr !== resume) begin
      $display("FAIL stall_resume got en=%b addr=%h exp 1 %h",
               obs_en, obs_addr, resume);
      miscompares++;
    end
  endtask

  task automatic test_full_wrap();
    int pops;
    do_reset();
    for (int i = 0; i < 12 && m_q.size() != 4; i++) tick();
    tick();
    vectors++;
    if (obs_cnt !== 3'd4 || obs_en !== 1'b0) begin
      $display("FAIL full got cnt=%0d en=%b exp 4 0", obs_cnt, obs_en);
      miscompares++;
    end
    ds_allow_in = 1'b1;
    pops = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (obs_valid) pops++;
      vectors++;
      if (obs_vec !== exp_vec) begin
        $display("FAIL wrap got %h exp %h", obs_vec, exp_vec);
        miscompares++;
      end
    end
    vectors++;
    if (pops < 8) begin
      $display("FAIL wrap_pops got %0d exp >=8", pops);
      miscompares++;
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 12 && !(m_q.size() == 2 && m_inf); i++) tick();
    reset = 1'b1;
    tick();
    tick();
    vectors++;
    if (obs_cnt !== 3'd0 || obs_valid !== 1'b0 || obs_en !== 1'b0) begin
      $display("FAIL mid_reset got cnt=%0d v=%b en=%b exp 0 0 0",
               obs_cnt, obs_valid, obs_en);
      miscompares++;
    end
    reset = 1'b0;
    ds_allow_in = 1'b1;
    for (int i = 0; i < 6 && !obs_valid; i++) tick();
    vectors++;
    if (obs_valid !== 1'b1 || obs_pc !== RST_PC) begin
      $display("FAIL mid_reset_pc got v=%b pc=%h exp 1 %h",
               obs_valid, obs_pc, RST_PC);
      miscompares++;
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      ds_allow_in = ($urandom_range(0, 3) != 0);
      stall = ($urandom_range(0, 5) == 0);
      br_taken = ($urandom_range(0, 19) == 0);
      br_target = RST_PC + ($urandom_range(0, 255) << 2);
      tick();
      vectors++;
      if (obs_vec !== exp_vec) begin
        $display("FAIL random cyc=%0d got %h exp %h", i, obs_vec, exp_vec);
        miscompares++;
      end
    end
    stall = 1'b0;
    br_taken = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    stall = 1'b0;
    br_taken = 1'b0;
    br_target = 32'h0;
    ds_allow_in = 1'b0;
    inst_sram_rdata = 32'h0;
    last_req = 32'h0;
    test_reset();
    test_backpressure();
    test_redirect();
    test_stall();
    test_full_wrap();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
